// File: rtl/ppi_bus_sequencer_if.sv
// Host command / response channel and 8255 bus pins of the PPI cycle sequencer.
// The slave view belongs to the sequencer; the master view is the host and PPI side.
interface ppi_bus_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_port;
    logic [7:0] req_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       CS;
    logic       RD;
    logic       WR;
    logic [1:0] A;
    logic [7:0] D_out;
    logic       D_oe;
    logic [7:0] D_in;
    logic [7:0] mode_word;
    logic       busy;

    modport slave (
        input  req_valid, req_op, req_port, req_data, D_in,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output CS, RD, WR, A, D_out, D_oe, mode_word, busy
    );

    modport master (
        output req_valid, req_op, req_port, req_data, D_in,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  CS, RD, WR, A, D_out, D_oe, mode_word, busy
    );
endinterface

// File: rtl/ppi_bus_sequencer.sv
// Converts one host command at a time into a timed 8255 PPI bus cycle.
// Define PPI_SEQ_AUTO_CFG_EN to write INIT_CW to the PPI automatically after reset.
module ppi_bus_sequencer #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
`ifdef PPI_SEQ_AUTO_CFG_EN
    ,
    parameter logic [7:0]  INIT_CW    = 8'h80
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    ppi_bus_sequencer_if.slave bus
);
    localparam logic [1:0] OP_PWR = 2'd0;
    localparam logic [1:0] OP_PRD = 2'd1;
    localparam logic [1:0] OP_CW  = 2'd2;
    localparam logic [1:0] OP_BSR = 2'd3;

    localparam logic [3:0] SETUP_LD  = (SETUP_CYC > 0) ? 4'(SETUP_CYC - 1) : 4'd0;
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

`ifdef PPI_SEQ_AUTO_CFG_EN
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP, S_CFG} state_t;
    localparam state_t RESET_STATE = S_CFG;
`else
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RESP} state_t;
    localparam state_t RESET_STATE = S_IDLE;
`endif

    // A zero SETUP_CYC makes the bus cycle open directly with the strobe.
    localparam state_t     ENTRY_STATE = (SETUP_CYC > 0) ? S_SETUP : S_STROBE;
    localparam logic [3:0] ENTRY_LD    = (SETUP_CYC > 0) ? SETUP_LD : STROBE_LD;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] op_q;
    logic       err_q;
    logic       auto_q;
    logic [1:0] a_q;
    logic [7:0] dout_q;
    logic       oe_q;
    logic       cs_q;
    logic       rd_q;
    logic       wr_q;
    logic       rsp_valid_q;
    logic       rsp_err_q;
    logic [7:0] rsp_data_q;
    logic [7:0] mode_q;

    logic       req_ready;
    logic       accept;
    logic       in_bus;
    logic       port_is_input;
    logic       reject;

    assign req_ready = (state_q == S_IDLE) && !RST;
    assign accept    = bus.req_valid && req_ready;
    assign in_bus    = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);

    // Screen commands against the shadow control word before any CS activity.
    always_comb begin
        port_is_input = 1'b1;
        case (bus.req_port)
            2'd0:    port_is_input = mode_q[4];
            2'd1:    port_is_input = mode_q[1];
            2'd2:    port_is_input = mode_q[0] | mode_q[3];
            default: port_is_input = 1'b1;
        endcase
        reject = 1'b0;
        if (!bus.req_op[1] && (bus.req_port == 2'd3)) begin
            reject = 1'b1;
        end else if ((bus.req_op == OP_CW) && !bus.req_data[7]) begin
            reject = 1'b1;
        end else if ((bus.req_op == OP_PWR) && port_is_input) begin
            reject = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= RESET_STATE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (reject) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = ENTRY_STATE;
                        cnt_d   = ENTRY_LD;
                    end
                end
            end
`ifdef PPI_SEQ_AUTO_CFG_EN
            S_CFG: begin
                if (INIT_CW[7]) begin
                    state_d = ENTRY_STATE;
                    cnt_d   = ENTRY_LD;
                end else begin
                    state_d = S_IDLE;
                end
            end
`endif
            S_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (HOLD_CYC > 0) begin
                        state_d = S_HOLD;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = S_RESP;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pins are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q        <= OP_PWR;
            err_q       <= 1'b0;
            auto_q      <= 1'b0;
            a_q         <= 2'd0;
            dout_q      <= 8'h00;
            oe_q        <= 1'b0;
            cs_q        <= 1'b1;
            rd_q        <= 1'b1;
            wr_q        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
            mode_q      <= 8'h9B;
        end else begin
            cs_q        <= !in_bus;
            rd_q        <= !((state_q == S_STROBE) && (op_q == OP_PRD));
            wr_q        <= !((state_q == S_STROBE) && (op_q != OP_PRD));
            oe_q        <= in_bus && (op_q != OP_PRD);
            rsp_valid_q <= (state_q == S_RESP) && !auto_q;
            rsp_err_q   <= (state_q == S_RESP) && !auto_q && err_q;
            // Sample D_in at the end of the last cycle RD is low on the pins.
            if (!rd_q && (state_q != S_STROBE)) begin
                rsp_data_q <= bus.D_in;
            end
            if (accept) begin
                op_q       <= bus.req_op;
                err_q      <= reject;
                auto_q     <= 1'b0;
                rsp_data_q <= 8'h00;
                if (!reject) begin
                    a_q <= bus.req_op[1] ? 2'd3 : bus.req_port;
                    if (bus.req_op == OP_BSR) begin
                        dout_q <= {4'h0, bus.req_data[3:0]};
                    end else if (bus.req_op != OP_PRD) begin
                        dout_q <= bus.req_data;
                    end
                    if (bus.req_op == OP_CW) begin
                        mode_q <= bus.req_data;
                    end
                end
            end
`ifdef PPI_SEQ_AUTO_CFG_EN
            if (state_q == S_CFG) begin
                op_q   <= OP_CW;
                err_q  <= 1'b0;
                auto_q <= 1'b1;
                if (INIT_CW[7]) begin
                    a_q    <= 2'd3;
                    dout_q <= INIT_CW;
                    mode_q <= INIT_CW;
                end
            end
`endif
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.CS        = cs_q;
    assign bus.RD        = rd_q;
    assign bus.WR        = wr_q;
    assign bus.A         = a_q;
    assign bus.D_out     = dout_q;
    assign bus.D_oe      = oe_q;
    assign bus.mode_word = mode_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Randomized bench for ppi_bus_sequencer: a command-level reference model predicts
// rejection, bus-cycle timing, address/data and responses for every command.
module tb_ppi_bus_sequencer;
    localparam int S = 1;
    localparam int T = 2;
    localparam int H = 1;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] mw;
    int         n_checks = 0;
    int         n_pass = 0;
    int         txn = 0;

    ppi_bus_sequencer_if ifc ();

    ppi_bus_sequencer #(
        .SETUP_CYC (S),
        .STROBE_CYC(T),
        .HOLD_CYC  (H)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(ifc)
    );

    always #5 CLK = ~CLK;

    // PPI model: returns the read value only while RD is low, garbage otherwise.
    always @(negedge CLK) ifc.D_in = ifc.RD ? 8'($urandom) : rd_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    // Ports currently programmed as inputs, from the 8255 mode-word bit meanings.
    function automatic bit is_input_port(input logic [1:0] port, input logic [7:0] m);
        bit pa_in, pb_in, pc_in;
        pa_in = m[4];
        pb_in = m[1];
        pc_in = m[3] || m[0];
        if (port == 2'd0) return pa_in;
        if (port == 2'd1) return pb_in;
        return pc_in;
    endfunction

    function automatic bit model_reject(input logic [1:0] op, input logic [1:0] port,
                                        input logic [7:0] data, input logic [7:0] m);
        if ((op == 2'd0 || op == 2'd1) && port == 2'd3) return 1'b1;
        if (op == 2'd2) return !data[7];
        if (op == 2'd0) return is_input_port(port, m);
        return 1'b0;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [1:0] port,
                           input logic [7:0] data, input logic [7:0] rv);
        bit rej, rd_seen, wr_seen, both, abad, dbad, rbad;
        logic [1:0] ea;
        logic [7:0] ed, erd, got_data;
        logic got_err;
        int elat, lat, w, cs_first, cs_cnt, st_first, st_cnt;
        rej  = model_reject(op, port, data, mw);
        ea   = (op >= 2'd2) ? 2'd3 : port;
        ed   = (op == 2'd3) ? {4'h0, data[3:0]} : data;
        erd  = (!rej && op == 2'd1) ? rv : 8'h00;
        elat = rej ? 1 : S + T + H + 1;
        if (!rej && op == 2'd2) mw = data;
        rd_val = rv;
        w = 0;
        while (!ifc.req_ready && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk("ready_timeout", (w < 50), 1);
        ifc.req_op = op;
        ifc.req_port = port;
        ifc.req_data = data;
        ifc.req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ifc.req_valid = 1'b0;
        ifc.req_op = 2'($urandom);
        ifc.req_port = 2'($urandom);
        ifc.req_data = 8'($urandom);
        lat = 99; cs_first = -1; cs_cnt = 0; st_first = -1; st_cnt = 0;
        rd_seen = 0; wr_seen = 0; both = 0; abad = 0; dbad = 0; rbad = 0;
        got_data = 8'h00; got_err = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                @(negedge CLK);
            end
            if (ifc.rsp_valid) begin
                lat = k;
                got_data = ifc.rsp_data;
                got_err = ifc.rsp_err;
                break;
            end
            if (ifc.req_ready || !ifc.busy) rbad = 1;
            if (!ifc.CS) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = k;
                if (ifc.A !== ea) abad = 1;
                if (op == 2'd1) begin
                    if (ifc.D_oe !== 1'b0) dbad = 1;
                end else if (ifc.D_out !== ed || ifc.D_oe !== 1'b1) begin
                    dbad = 1;
                end
            end else if (ifc.D_oe !== 1'b0) begin
                dbad = 1;
            end
            if (!ifc.RD || !ifc.WR) begin
                st_cnt++;
                if (st_first < 0) st_first = k;
                if (!ifc.RD) rd_seen = 1;
                if (!ifc.WR) wr_seen = 1;
                if ((!ifc.RD && !ifc.WR) || ifc.CS) both = 1;
            end
        end
        chk("latency", lat, elat);
        chk("rsp_err", got_err, rej);
        chk("rsp_data", got_data, erd);
        chk("mode_word", ifc.mode_word, mw);
        chk("strobe_kind", {wr_seen, rd_seen}, rej ? 2'd0 : ((op == 2'd1) ? 2'd1 : 2'd2));
        chk("cs_cycles", cs_cnt, rej ? 0 : S + T + H);
        chk("strobe_cycles", st_cnt, rej ? 0 : T);
        if (!rej) begin
            chk("cs_first", cs_first, 1);
            chk("strobe_first", st_first, S + 1);
        end
        chk("addr_stable", abad, 0);
        chk("data_stable", dbad, 0);
        chk("strobe_overlap", both, 0);
        chk("ready_while_busy", rbad, 0);
        $display("txn %0d op=%0d port=%0d data=%02h rsp_data=%02h err=%0b lat=%0d mode=%02h",
                 txn, op, port, data, got_data, got_err, lat, ifc.mode_word);
        txn++;
        @(posedge CLK);
        @(negedge CLK);
        chk("rsp_pulse", ifc.rsp_valid, 0);
    endtask

    initial begin
        bit seen;
        int w;
        ifc.req_valid = 1'b0;
        ifc.req_op = 2'd0;
        ifc.req_port = 2'd0;
        ifc.req_data = 8'h00;
        ifc.D_in = 8'h00;
        mw = 8'h9B;
        repeat (3) @(negedge CLK);
        chk("rst_ready", ifc.req_ready, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_cs", ifc.CS, 1);
        chk("rst_rd", ifc.RD, 1);
        chk("rst_wr", ifc.WR, 1);
        chk("rst_a", ifc.A, 0);
        chk("rst_dout", ifc.D_out, 0);
        chk("rst_doe", ifc.D_oe, 0);
        chk("rst_rsp_valid", ifc.rsp_valid, 0);
        chk("rst_rsp_err", ifc.rsp_err, 0);
        chk("rst_rsp_data", ifc.rsp_data, 0);
        chk("rst_mode", ifc.mode_word, 8'h9B);
        chk("rst_busy", ifc.busy, 0);
        chk("idle_ready", ifc.req_ready, 1);

        run_cmd(2'd0, 2'd0, 8'h11, 8'h00);
        run_cmd(2'd2, 2'd0, 8'h05, 8'h00);
        run_cmd(2'd3, 2'd2, 8'hFB, 8'h00);
        run_cmd(2'd1, 2'd3, 8'h00, 8'h55);
        run_cmd(2'd1, 2'd2, 8'h00, 8'h3C);
        run_cmd(2'd2, 2'd0, 8'h80, 8'h00);
        run_cmd(2'd0, 2'd1, 8'hA5, 8'h00);
        run_cmd(2'd0, 2'd2, 8'h5A, 8'h00);

        // Reset lands on the first strobe edge of a control-word write.
        ifc.req_op = 2'd2;
        ifc.req_port = 2'd0;
        ifc.req_data = 8'h92;
        ifc.req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        ifc.req_valid = 1'b0;
        w = 0;
        while (ifc.CS && w < 20) begin
            @(posedge CLK);
            @(negedge CLK);
            w++;
        end
        chk("mid_cs_low", ifc.CS, 0);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("mid_cs", ifc.CS, 1);
        chk("mid_wr", ifc.WR, 1);
        chk("mid_doe", ifc.D_oe, 0);
        chk("mid_rsp_valid", ifc.rsp_valid, 0);
        chk("mid_mode", ifc.mode_word, 8'h9B);
        chk("mid_ready", ifc.req_ready, 0);
        RST = 1'b0;
        mw = 8'h9B;
        seen = 0;
        repeat (8) begin
            @(negedge CLK);
            if (ifc.rsp_valid) seen = 1;
        end
        chk("mid_no_rsp", seen, 0);

        run_cmd(2'd2, 2'd0, 8'h80, 8'h00);
        for (int i = 0; i < 150; i++) begin
            logic [1:0] op, port;
            logic [7:0] data, rv;
            op = 2'($urandom);
            port = 2'($urandom);
            data = 8'($urandom);
            rv = 8'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
            run_cmd(op, port, data, rv);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ppi_bus_sequencer.md
# ppi_bus_sequencer

Host-side cycle sequencer for the 8255-style PPI. It accepts one command at a time over a valid/ready interface and converts it into a timed PPI bus cycle on CS/RD/WR/A/D: a control-word write, a BSR bit set or reset, or a port A/B/C read or write. It keeps a shadow copy of the programmed control word and rejects writes to ports configured as inputs. It sits between the system bus master and the PPI top level.

## Interface
Parameters:
- SETUP_CYC, 1, cycles with CS low and A/D valid before the strobe (0..15; 0 skips SETUP)
- STROBE_CYC, 2, cycles RD or WR is held low (1..15)
- HOLD_CYC, 1, cycles with CS low and A/D held after the strobe (0..15; 0 skips HOLD)
- INIT_CW, 8'h80, control word written automatically after reset (used only with PPI_SEQ_AUTO_CFG_EN)

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  sequencer can accept a command
- req_op  in  2  00 port write, 01 port read, 10 control-word write, 11 BSR
- req_port  in  2  0=A, 1=B, 2=C; ignored for ops 10/11
- req_data  in  8  write data / control word / BSR nibble in [3:0]
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  8  read data; 0 for non-reads
- rsp_err  out  1  command rejected; no bus cycle issued
- CS, RD, WR  out  1 each  active-low PPI strobes
- A  out  2  PPI address
- D_out  out  8  data driven to the PPI
- D_oe  out  1  D_out drive enable; the top level tristates when low
- D_in  in  8  data returned by the PPI
- mode_word  out  8  shadow of the last accepted control word
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, CFG (macro only), SETUP, STROBE, HOLD, RESP.
- A command is accepted on an edge where req_valid && req_ready. req_ready = (state==IDLE).
- Accepted command fields are registered. Inputs may change after the accept edge.
- Address mapping: port ops drive A=req_port. Ops 10 and 11 drive A=3.
- Data mapping:
  - Op 10 drives D_out=req_data.
  - Op 11 drives D_out={4'b0000, req_data[3:0]}: bits [3:1] select the PC bit, bit [0] is the value.
- Rejections go IDLE→RESP with rsp_err=1 and no CS activity:
  - port op with req_port==3
  - op 10 with req_data[7]==0
  - op 00 to a port the shadow marks as input: A if mode_word[4], B if mode_word[1], C if mode_word[0] or mode_word[3]
- Reads are always allowed.
- mode_word updates on acceptance of a valid op 10. BSR never changes mode_word.
- SETUP: CS=0, A valid, RD=WR=1. D_oe=1 for writes.
- STROBE: RD=0 (op 01) or WR=0 (ops 00/10/11). D_in is captured into rsp_data on the last STROBE edge.
- HOLD: RD=WR=1, CS=0, A and D_out/D_oe unchanged.
- RESP: CS=1, D_oe=0, rsp_valid=1 for exactly one cycle, then IDLE.
- The cycle counter is 4 bits wide and reloads on every state entry.

## Timing
- Reset values:
  - CS=RD=WR=1, A=0, D_out=0, D_oe=0
  - rsp_valid=0, rsp_err=0, rsp_data=0
  - mode_word=8'h9B (all ports input)
  - req_ready=0 while RST=1
- Latency: with the accept edge as edge 0, rsp_valid is high in the cycle after edge SETUP_CYC+STROBE_CYC+HOLD_CYC+1. The default is edge 5.
- Rejected commands give rsp_valid in the cycle after edge 1.
- Back-to-back commands: req_ready rises in the cycle after RESP. This gives a minimum of one IDLE cycle between bus cycles, so CS always deasserts for at least 2 cycles between accesses.
- RD and WR are never low together. A and D_out never change while CS=0.
- RST mid-cycle: all outputs return to reset values on that edge, no response is issued, and the command is dropped.
- req_valid while busy: the command is held off and not lost. The master must keep it stable until accepted.

## Configuration
- PPI_SEQ_AUTO_CFG_EN defined: after RST the FSM enters CFG and performs one op-10 write of INIT_CW with normal SETUP/STROBE/HOLD timing.
  - No rsp_valid is issued for this write.
  - mode_word=INIT_CW afterwards.
  - req_ready stays 0 until it completes.
  - If INIT_CW[7]==0 the write is skipped and mode_word stays 8'h9B.
- PPI_SEQ_AUTO_CFG_EN undefined: the CFG state is absent, and FSM and req_ready go straight to IDLE/1 after reset.

## Test plan
- Reset, then op10 data 8'h80 (defaults): CS=0 on edges 1–4, WR=0 on edges 2–3, A=3, D_out=8'h80, rsp_valid at cycle 5 with rsp_err=0, mode_word=8'h80.
- After 8'h80 is programmed, op00 port B data 8'hA5: WR pulse with A=1, D_out=8'hA5, D_oe=1 throughout CS low; response rsp_err=0.
- Op01 port C while D_in=8'h3C during STROBE: RD low for 2 cycles, rsp_data=8'h3C. Also op01 port 3: rsp_err=1 at cycle 1 with CS never low.
- From reset with mode_word=9B, op00 port A: rsp_err=1, no strobe. Op10 8'h05: rsp_err=1, mode_word unchanged. Op11 nibble 4'b1011: D_out=8'h0B, A=3, mode_word unchanged.
- Assert RST on the first STROBE edge of a write: CS/WR/D_oe return high/low on that edge, no rsp_valid, and the next command works normally.
- With PPI_SEQ_AUTO_CFG_EN and INIT_CW=8'h89: req_ready=0 until a WR pulse with D_out=8'h89 completes, no rsp_valid is issued, then mode_word=8'h89 and req_ready=1.
